imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Parametrised, pipelined immediate generator for the decode stage. It covers all RV32I
//  immediate formats (I, S, B, U, J), sign-extended to XLEN.
//  It sits between instruction fetch and the register-read stage.
//  Both sides use a valid/ready handshake, with a 2-entry skid buffer on the output.
//  Each result carries a format tag and an illegal-opcode flag.
//  A saturating counter tracks how many illegal opcodes have been accepted.
// PARAMETERS
//  XLEN   32  immediate output width; legal values 32 or 64; sign-extension fills bits XLEN-1:32
//  CNT_W  16  width of the saturating illegal-opcode counter
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous active-low reset
//  flush       in   1       synchronous pipeline flush (branch mispredict / trap)
//  in_valid    in   1       InstCode is valid this cycle
//  in_ready    out  1       block can accept an instruction
//  InstCode    in   32      instruction word
//  out_valid   out  1       ImmOut/ImmFmt/IllegalOp are valid
//  out_ready   in   1       downstream accepts the output
//  ImmOut      out  XLEN    sign-extended immediate
//  ImmFmt      out  3       0=R 1=I 2=S 3=B 4=U 5=J 7=NONE(illegal)
//  IllegalOp   out  1       opcode is not in the supported set
//  IllegalCnt  out  CNT_W   saturating count of accepted illegal opcodes
// BEHAVIOUR
//  Reset (rst_n=0, async): both skid entries empty.
//   out_valid=0, ImmOut=0, ImmFmt=0, IllegalOp=0, IllegalCnt=0, in_ready=1 once rst_n deasserts.
//  Decode (combinational, from InstCode[6:0]):
//   I  0000011, 0010011, 1100111 -> {sext(IC[31]), IC[31:20]}
//   S  0100011                   -> {sext, IC[31:25], IC[11:7]}
//   B  1100011                   -> {sext, IC[31], IC[7], IC[30:25], IC[11:8], 1'b0}
//   U  0110111, 0010111          -> {sext(IC[31]) above bit 31, IC[31:12], 12'b0}
//   J  1101111                   -> {sext, IC[31], IC[19:12], IC[20], IC[30:21], 1'b0}
//   R  0110011                   -> imm 0, legal
//   any other opcode             -> imm 0, ImmFmt=7, IllegalOp=1
//  Handshake:
//   - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
//   - in_ready = !entry1_full, a registered signal. It has no combinational path from out_ready.
//   - Latency is 1 cycle: an accepted instruction appears on the outputs the next cycle.
//   - Outputs hold stable while out_valid=1 and out_ready=0.
//   - Order is strictly FIFO.
//   - When the output entry is full and not draining, the next input goes to entry1, and in_ready drops.
//   - When both entries are full, a pop moves entry1 into entry0 in the same edge.
//     If in_valid is also high that cycle, the push is refused because in_ready was 0.
//   - Simultaneous push and pop with one entry occupied: the new word replaces entry0. Occupancy stays 1.
//  Flush (sync, highest priority): on the next edge both entries are emptied and out_valid=0.
//   - The input offered in the flush cycle is dropped and not counted.
//   - IllegalCnt is unaffected.
//   - ImmOut and friends keep their old values, but are don't-care while out_valid=0.
//  IllegalCnt: +1 on each input transfer with an illegal opcode. It saturates at all-ones; no wrap.
//  When out_valid=0, data outputs are don't-care. The bench must not check them.
// STRUCTURE
//  Package imm_gen_pkg holds:
//   - opcode localparams (OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_OP)
//   - the imm_fmt_e encoding (FMT_R..FMT_J, FMT_NONE=3'd7)
//  Sub-module imm_decode #(XLEN) is purely combinational.
//   - Inputs: InstCode. Outputs: imm, fmt, illegal.
//   - It is instantiated once and feeds the skid buffer.
//  Top level contains the 2-entry skid buffer and the counter; no other state.
// TESTING
//  1 Reset then ADDI x1,x0,-1 (0xFFF00093), out_ready=1
//    -> next cycle out_valid=1, ImmOut=0xFFFFFFFF, ImmFmt=1.
//  2 Run each format:
//    - SW imm=-4 (0xFE112E23) -> 0xFFFFFFFC, fmt 2.
//    - BEQ imm=+8 (0x00000463) -> 0x8, fmt 3.
//    - LUI 0x12345 (0x123450B7) -> 0x12345000, fmt 4.
//    - JAL imm=-2 (0xFFFFF0EF) -> 0xFFFFFFFE, fmt 5.
//  3 Backpressure: hold out_ready=0 and stream 3 words
//    -> in_ready=0 after 2 accepted; outputs stable.
//    Then release -> words pop in order, one per cycle.
//  4 Illegal opcode 0x0000007F sent 3 times -> IllegalOp=1, fmt=7, ImmOut=0, IllegalCnt=3.
//    With CNT_W=2, 5 illegals -> IllegalCnt=3 (saturated).
//  5 Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1.
//    The dropped word never appears, and IllegalCnt is unchanged.
//  6 XLEN=64, LUI 0x80000 (0x800000B7) -> ImmOut=0xFFFFFFFF80000000.
//    Also assert rst_n low mid-stream -> all outputs zero immediately, without a clock edge.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg
//   Shared definitions for the immediate-generator slice: the RV32I major
//   opcodes the decoder recognises and the format tag carried with each result.
package imm_gen_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } imm_fmt_e;

endpackage

// File: rtl/imm_decode.sv
// imm_decode
//   Purely combinational immediate extraction for all RV32I formats.
//   The 32-bit immediate is sign-extended to XLEN (32 or 64).
// Ports
//   InstCode  in  32    instruction word
//   imm       out XLEN  sign-extended immediate (0 for R-type and illegal opcodes)
//   fmt       out 3     format tag (imm_fmt_e)
//   illegal   out 1     opcode not in the supported set
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     InstCode,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    logic signed [31:0] imm32_s;

    // Opcode decode and field gathering into a 32-bit signed immediate
    always_comb begin
        imm32_s = 32'sd0;
        fmt     = FMT_NONE;
        illegal = 1'b1;
        case (InstCode[6:0])
            OP_LOAD, OP_IMM, OP_JALR: begin
                imm32_s = {{20{InstCode[31]}}, InstCode[31:20]};
                fmt     = FMT_I;
                illegal = 1'b0;
            end
            OP_STORE: begin
                imm32_s = {{20{InstCode[31]}}, InstCode[31:25], InstCode[11:7]};
                fmt     = FMT_S;
                illegal = 1'b0;
            end
            OP_BRANCH: begin
                imm32_s = {{19{InstCode[31]}}, InstCode[31], InstCode[7],
                           InstCode[30:25], InstCode[11:8], 1'b0};
                fmt     = FMT_B;
                illegal = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                imm32_s = {InstCode[31:12], 12'b0};
                fmt     = FMT_U;
                illegal = 1'b0;
            end
            OP_JAL: begin
                imm32_s = {{11{InstCode[31]}}, InstCode[31], InstCode[19:12],
                           InstCode[20], InstCode[30:21], 1'b0};
                fmt     = FMT_J;
                illegal = 1'b0;
            end
            OP_OP: begin
                imm32_s = 32'sd0;
                fmt     = FMT_R;
                illegal = 1'b0;
            end
            default: begin
                imm32_s = 32'sd0;
                fmt     = FMT_NONE;
                illegal = 1'b1;
            end
        endcase
    end

    // Signed size cast replicates bit 31 into bits XLEN-1:32 when XLEN=64
    assign imm = XLEN'(imm32_s);

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Decode-stage immediate generator: one combinational decoder feeding a
//   2-entry skid buffer, plus a saturating count of accepted illegal opcodes.
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              synchronous flush; empties the buffer, drops the offered word
//   in_valid/in_ready  upstream handshake (in_ready is registered: !entry1_full)
//   InstCode           instruction word
//   out_valid/out_ready downstream handshake
//   ImmOut, ImmFmt, IllegalOp  result held in entry0
//   IllegalCnt         saturating count of accepted illegal opcodes
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      InstCode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ImmOut,
    output logic [2:0]       ImmFmt,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] IllegalCnt
);

    logic [XLEN-1:0]  dec_imm_s;
    imm_fmt_e         dec_fmt_s;
    logic             dec_ill_s;

    logic             e0_valid_r;
    logic [XLEN-1:0]  e0_imm_r;
    imm_fmt_e         e0_fmt_r;
    logic             e0_ill_r;
    logic             e1_valid_r;
    logic [XLEN-1:0]  e1_imm_r;
    imm_fmt_e         e1_fmt_r;
    logic             e1_ill_r;
    logic [CNT_W-1:0] cnt_r;

    logic             push_s;
    logic             pop_s;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .InstCode (InstCode),
        .imm      (dec_imm_s),
        .fmt      (dec_fmt_s),
        .illegal  (dec_ill_s)
    );

    // in_ready depends only on entry1 state, so there is no path from out_ready
    assign in_ready   = ~e1_valid_r;
    assign push_s     = in_valid & in_ready;
    assign pop_s      = e0_valid_r & out_ready;

    assign out_valid  = e0_valid_r;
    assign ImmOut     = e0_imm_r;
    assign ImmFmt     = e0_fmt_r;
    assign IllegalOp  = e0_ill_r;
    assign IllegalCnt = cnt_r;

    // Skid buffer: entry0 drives the outputs, entry1 catches one word under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_valid_r <= 1'b0;
            e0_imm_r   <= '0;
            e0_fmt_r   <= FMT_R;
            e0_ill_r   <= 1'b0;
            e1_valid_r <= 1'b0;
            e1_imm_r   <= '0;
            e1_fmt_r   <= FMT_R;
            e1_ill_r   <= 1'b0;
        end else if (flush) begin
            // Data registers keep their contents; only occupancy is cleared
            e0_valid_r <= 1'b0;
            e1_valid_r <= 1'b0;
        end else begin
            case ({e0_valid_r, e1_valid_r})
                2'b00: begin
                    if (push_s) begin
                        e0_valid_r <= 1'b1;
                        e0_imm_r   <= dec_imm_s;
                        e0_fmt_r   <= dec_fmt_s;
                        e0_ill_r   <= dec_ill_s;
                    end
                end
                2'b10: begin
                    if (push_s && pop_s) begin
                        // Pass-through: the new word replaces the departing one
                        e0_imm_r <= dec_imm_s;
                        e0_fmt_r <= dec_fmt_s;
                        e0_ill_r <= dec_ill_s;
                    end else if (push_s) begin
                        e1_valid_r <= 1'b1;
                        e1_imm_r   <= dec_imm_s;
                        e1_fmt_r   <= dec_fmt_s;
                        e1_ill_r   <= dec_ill_s;
                    end else if (pop_s) begin
                        e0_valid_r <= 1'b0;
                    end
                end
                2'b11: begin
                    // in_ready was 0, so only a pop can happen here
                    if (pop_s) begin
                        e0_imm_r   <= e1_imm_r;
                        e0_fmt_r   <= e1_fmt_r;
                        e0_ill_r   <= e1_ill_r;
                        e1_valid_r <= 1'b0;
                    end
                end
                default: begin
                    // Entry1 alone is unreachable; promote it so order is kept
                    e0_valid_r <= 1'b1;
                    e0_imm_r   <= e1_imm_r;
                    e0_fmt_r   <= e1_fmt_r;
                    e0_ill_r   <= e1_ill_r;
                    e1_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Saturating illegal-opcode counter; words dropped by a flush are not counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (!flush && push_s && dec_ill_s && !(&cnt_r)) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe
//   Drives three instances from one stimulus stream: XLEN=32/CNT_W=16,
//   XLEN=64/CNT_W=16 and XLEN=32/CNT_W=2. A queue-based FIFO model with an
//   arithmetic immediate reference predicts every output; table vectors and
//   hand sequences add fixed expectations.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] ic;
    logic        out_ready;

    logic        ir_a, ov_a, ill_a;
    logic [31:0] imm_a;
    logic [2:0]  fmt_a;
    logic [15:0] cnt_a;
    logic        ir_b, ov_b, ill_b;
    logic [63:0] imm_b;
    logic [2:0]  fmt_b;
    logic [15:0] cnt_b;
    logic        ir_c, ov_c, ill_c;
    logic [31:0] imm_c;
    logic [2:0]  fmt_c;
    logic [1:0]  cnt_c;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir_a),
        .InstCode(ic), .out_valid(ov_a), .out_ready(out_ready), .ImmOut(imm_a),
        .ImmFmt(fmt_a), .IllegalOp(ill_a), .IllegalCnt(cnt_a));

    imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir_b),
        .InstCode(ic), .out_valid(ov_b), .out_ready(out_ready), .ImmOut(imm_b),
        .ImmFmt(fmt_b), .IllegalOp(ill_b), .IllegalCnt(cnt_b));

    imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir_c),
        .InstCode(ic), .out_valid(ov_c), .out_ready(out_ready), .ImmOut(imm_c),
        .ImmFmt(fmt_c), .IllegalOp(ill_c), .IllegalCnt(cnt_c));

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] ic;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    exp_t q[$];
    int   raw_cnt;
    int   n_vec;
    int   n_bad;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference immediate computed from the format rules with plain arithmetic
    function automatic exp_t ref_decode(logic [31:0] w);
        exp_t   e;
        longint v;
        v = 0;
        e.fmt = 3'd7;
        e.ill = 1'b1;
        case (w[6:0])
            7'h03, 7'h13, 7'h67: begin
                v = longint'(w[31:20]) - (w[31] ? 64'sd4096 : 64'sd0);
                e.fmt = 3'd1; e.ill = 1'b0;
            end
            7'h23: begin
                v = longint'(w[31:25]) * 32 + longint'(w[11:7]) - (w[31] ? 64'sd4096 : 64'sd0);
                e.fmt = 3'd2; e.ill = 1'b0;
            end
            7'h63: begin
                v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2
                    - (w[31] ? 64'sd4096 : 64'sd0);
                e.fmt = 3'd3; e.ill = 1'b0;
            end
            7'h37, 7'h17: begin
                v = longint'(w[31:12]) * 4096 - (w[31] ? 64'sd4294967296 : 64'sd0);
                e.fmt = 3'd4; e.ill = 1'b0;
            end
            7'h6F: begin
                v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2
                    - (w[31] ? 64'sd1048576 : 64'sd0);
                e.fmt = 3'd5; e.ill = 1'b0;
            end
            7'h33: begin
                e.fmt = 3'd0; e.ill = 1'b0;
            end
            default: begin
                e.fmt = 3'd7; e.ill = 1'b1;
            end
        endcase
        e.imm = v;
        return e;
    endfunction

    // FIFO model update at the active edge, using the inputs the DUT samples
    task automatic model_update();
        bit   do_pop, do_push;
        exp_t e;
        if (!rst_n) begin
            q.delete();
            raw_cnt = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            do_pop  = (q.size() > 0) && out_ready;
            do_push = in_valid && (q.size() < 2);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e = ref_decode(ic);
                q.push_back(e);
                if (e.ill) raw_cnt++;
            end
        end
    endtask

    task automatic check_model();
        logic [63:0] ea, ec;
        ea = (raw_cnt > 65535) ? 64'd65535 : 64'(raw_cnt);
        ec = (raw_cnt > 3) ? 64'd3 : 64'(raw_cnt);
        chk("out_valid_a", 64'(ov_a), 64'(q.size() > 0));
        chk("out_valid_b", 64'(ov_b), 64'(q.size() > 0));
        chk("out_valid_c", 64'(ov_c), 64'(q.size() > 0));
        chk("in_ready_a", 64'(ir_a), 64'(q.size() < 2));
        chk("in_ready_b", 64'(ir_b), 64'(q.size() < 2));
        chk("in_ready_c", 64'(ir_c), 64'(q.size() < 2));
        chk("cnt_a", 64'(cnt_a), ea);
        chk("cnt_b", 64'(cnt_b), ea);
        chk("cnt_c", 64'(cnt_c), ec);
        if (q.size() > 0) begin
            chk("imm_a", 64'(imm_a), 64'(q[0].imm[31:0]));
            chk("imm_b", imm_b, q[0].imm);
            chk("imm_c", 64'(imm_c), 64'(q[0].imm[31:0]));
            chk("fmt_a", 64'(fmt_a), 64'(q[0].fmt));
            chk("fmt_b", 64'(fmt_b), 64'(q[0].fmt));
            chk("ill_a", 64'(ill_a), 64'(q[0].ill));
            chk("ill_c", 64'(ill_c), 64'(q[0].ill));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_model();
    endtask

    vec_t        tbl[12];
    logic [6:0]  opc[10];
    logic [31:0] r;
    logic [63:0] cnt_before;

    initial begin
        n_vec = 0; n_bad = 0; raw_cnt = 0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; ic = 32'h0; out_ready = 1'b1;

        tbl[0]  = '{32'hFFF00093, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0};
        tbl[1]  = '{32'hFE112E23, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0};
        tbl[2]  = '{32'h00000463, 64'h00000000_00000008, 3'd3, 1'b0};
        tbl[3]  = '{32'h123450B7, 64'h00000000_12345000, 3'd4, 1'b0};
        tbl[4]  = '{32'hFFFFF0EF, 64'hFFFFFFFF_FFFFFFFE, 3'd5, 1'b0};
        tbl[5]  = '{32'h800000B7, 64'hFFFFFFFF_80000000, 3'd4, 1'b0};
        tbl[6]  = '{32'hFE000EE3, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 1'b0};
        tbl[7]  = '{32'h002081B3, 64'h00000000_00000000, 3'd0, 1'b0};
        tbl[8]  = '{32'h0000007F, 64'h00000000_00000000, 3'd7, 1'b1};
        tbl[9]  = '{32'h00001017, 64'h00000000_00001000, 3'd4, 1'b0};
        tbl[10] = '{32'hFF812083, 64'hFFFFFFFF_FFFFFFF8, 3'd1, 1'b0};
        tbl[11] = '{32'h00008067, 64'h00000000_00000000, 3'd1, 1'b0};

        opc = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(ov_a), 64'd0);
        chk("rst_imm", 64'(imm_a), 64'd0);
        chk("rst_fmt", 64'(fmt_a), 64'd0);
        chk("rst_ill", 64'(ill_a), 64'd0);
        chk("rst_cnt", 64'(cnt_a), 64'd0);
        rst_n = 1'b1;
        check_model();

        // Table vectors, one word at a time with out_ready high
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; ic = tbl[i].ic; out_ready = 1'b1;
            cycle();
            in_valid = 1'b0;
            chk("tbl_valid", 64'(ov_a), 64'd1);
            chk("tbl_imm32", 64'(imm_a), 64'(tbl[i].imm[31:0]));
            chk("tbl_imm64", imm_b, tbl[i].imm);
            chk("tbl_fmt", 64'(fmt_a), 64'(tbl[i].fmt));
            chk("tbl_ill", 64'(ill_a), 64'(tbl[i].ill));
            cycle();
        end

        // Backpressure: three words offered while out_ready is low
        out_ready = 1'b0; in_valid = 1'b1; ic = 32'hFFF00093;
        cycle();
        chk("bp_imm_w1", 64'(imm_a), 64'hFFFFFFFF);
        chk("bp_ready_1", 64'(ir_a), 64'd1);
        ic = 32'h00000463;
        cycle();
        chk("bp_ready_2", 64'(ir_a), 64'd0);
        chk("bp_hold_1", 64'(imm_a), 64'hFFFFFFFF);
        ic = 32'h123450B7;
        cycle();
        chk("bp_ready_3", 64'(ir_a), 64'd0);
        chk("bp_hold_2", 64'(imm_a), 64'hFFFFFFFF);
        out_ready = 1'b1;
        cycle();
        chk("bp_pop_w2", 64'(imm_a), 64'h8);
        chk("bp_ready_4", 64'(ir_a), 64'd1);
        cycle();
        chk("bp_pop_w3", 64'(imm_a), 64'h12345000);
        in_valid = 1'b0;
        cycle();
        chk("bp_empty", 64'(ov_a), 64'd0);

        // Flush with both entries full and an illegal word offered
        out_ready = 1'b0; in_valid = 1'b1; ic = 32'h00001017;
        cycle();
        ic = 32'hFE112E23;
        cycle();
        cnt_before = 64'(raw_cnt);
        flush = 1'b1; ic = 32'h0000007F;
        cycle();
        chk("fl_valid", 64'(ov_a), 64'd0);
        chk("fl_ready", 64'(ir_a), 64'd1);
        chk("fl_cnt", 64'(cnt_a), cnt_before);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            cycle();
            chk("fl_no_ghost", 64'(ov_a), 64'd0);
        end

        // Asynchronous reset mid-stream, with both entries full
        out_ready = 1'b0; in_valid = 1'b1; ic = 32'h800000B7;
        cycle();
        cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid_a", 64'(ov_a), 64'd0);
        chk("arst_imm_b", imm_b, 64'd0);
        chk("arst_fmt", 64'(fmt_a), 64'd0);
        chk("arst_ill", 64'(ill_a), 64'd0);
        chk("arst_cnt", 64'(cnt_a), 64'd0);
        q.delete();
        raw_cnt = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_model();

        // Illegal opcodes back-to-back: count 3, then saturation of the 2-bit counter
        out_ready = 1'b1; in_valid = 1'b1; ic = 32'h0000007F;
        repeat (3) cycle();
        chk("ill_flag", 64'(ill_a), 64'd1);
        chk("ill_fmt", 64'(fmt_a), 64'd7);
        chk("ill_imm", 64'(imm_a), 64'd0);
        chk("ill_cnt3", 64'(cnt_a), 64'd3);
        repeat (2) cycle();
        chk("ill_cnt5", 64'(cnt_a), 64'd5);
        chk("ill_sat2", 64'(cnt_c), 64'd3);
        in_valid = 1'b0;
        cycle();

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            r = $urandom();
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            ic        = {r[31:7], opc[$urandom_range(0, 9)]};
            if ($urandom_range(0, 9) == 0) ic = r;
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
